// File: rtl/serializador_pkg.sv
`default_nettype none
// ============================================================================
// Module   : serializador_pkg
// Purpose  : Shared types and helpers for the parallel-to-serial shifter:
//            FSM state type, state encodings and bit-counter width.
// Revision : 1.0 - initial release
// ============================================================================
package serializador_pkg;

  // State encodings, kept as explicit constants so the enum stays legacy-friendly
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  typedef enum logic [0:0] {
    IDLE  = ST_IDLE,
    SHIFT = ST_SHIFT
  } state_t;

  // Width of the bit counter; at least one bit so WIDTH = 2 still has a counter
  function automatic int cnt_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage
`default_nettype wire

// File: rtl/serializador_paralelo_serial_contador_bits.sv
`default_nettype none
// ============================================================================
// Module   : contador_bits
// Purpose  : Down-counter of bits remaining in the current word. Loaded on
//            word accept, decremented per shifted bit, never wraps below 0.
// Revision : 1.0 - initial release
// ============================================================================
module contador_bits #(
  parameter int CW = 2
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          load_en,
  input  logic [CW-1:0] load_val,
  input  logic          dec_en,
  output logic [CW-1:0] cnt,
  output logic          zero
);

  // Load has priority; decrement only while nonzero so the counter cannot wrap
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (load_en) begin
      cnt <= load_val;
    end else if (dec_en && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule
`default_nettype wire

// File: rtl/serializador_paralelo_serial.sv
`default_nettype none
// ============================================================================
// Module   : serializador_paralelo_serial
// Purpose  : Parallel-in, serial-out shift register with load/ready handshake,
//            per-bit valid strobe and end-of-word done pulse. Back-to-back
//            loads produce a gapless bit stream.
// Revision : 1.0 - initial release
// ============================================================================
module serializador_paralelo_serial
  import serializador_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  output logic             ready,
  output logic             out,
  output logic             valid,
  output logic             done
);

  localparam int             CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0]  LAST_BIT = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] sreg;
  logic [CW-1:0]    cnt;
  logic             cnt_zero;
  logic             accept;
  logic             shift_en;

  // Outputs come only from registered state; load/data never reach them combinationally
  assign valid    = (state == SHIFT);
  assign ready    = (state == IDLE) || cnt_zero;
  assign done     = valid && cnt_zero;
  assign out      = valid && (MSB_FIRST ? sreg[WIDTH-1] : sreg[0]);
  assign accept   = load && ready;
  assign shift_en = valid && !cnt_zero;

  contador_bits #(
    .CW (CW)
  ) u_contador_bits (
    .clock    (clock),
    .reset    (reset),
    .load_en  (accept),
    .load_val (LAST_BIT),
    .dec_en   (shift_en),
    .cnt      (cnt),
    .zero     (cnt_zero)
  );

  // FSM and shift register: accept (also on the last bit), shift, or drop back to idle
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      sreg  <= '0;
    end else if (accept) begin
      state <= SHIFT;
      sreg  <= data;
    end else if (shift_en) begin
      sreg <= MSB_FIRST ? {sreg[WIDTH-2:0], 1'b0} : {1'b0, sreg[WIDTH-1:1]};
    end else if (valid) begin
      // last bit went out with no new word waiting
      state <= IDLE;
      sreg  <= '0;
    end
  end

endmodule
`default_nettype wire

// File: doc/serializador_paralelo_serial.md
# serializador_paralelo_serial

Parallel-in, serial-out shift register: accepts a WIDTH-bit word through a load/ready handshake and shifts it out one bit per clock with a per-bit valid strobe and an end-of-word pulse. It is the transmit end of the serial-in shift-register path and drives its serial input directly, so a word loaded here appears intact on the receiver's parallel outputs WIDTH clocks later. Back-to-back loads produce a gapless bit stream.

## Interface
- WIDTH, 4, word length in bits; legal range 2..32
- MSB_FIRST, 1, 1 = bit WIDTH-1 shifted first, 0 = bit 0 first
- clock  in  1  system clock; all state changes on rising edge
- reset  in  1  asynchronous, active-low; 0 forces reset state immediately
- load  in  1  word-load request; accepted only at an edge where ready = 1
- data  in  WIDTH  parallel word; sampled only at the accepting edge
- ready  out  1  block can accept a word at the next rising edge
- out  out  1  serial data bit; drives the receiver's serial input
- valid  out  1  out carries a word bit this cycle
- done  out  1  one-cycle pulse coincident with the last bit of a word

## Operation
- States: IDLE, SHIFT. Internal: shift register sreg[WIDTH-1:0], bit counter cnt of width $clog2(WIDTH).
- IDLE: ready = 1, valid = 0, out = 0, done = 0. On edge with load = 1: sreg <= data, cnt <= WIDTH-1, go to SHIFT.
- SHIFT: valid = 1; out = sreg[WIDTH-1] if MSB_FIRST else sreg[0]; done = (cnt == 0).
  - cnt != 0: shift sreg one position toward the output end, fill 0; cnt <= cnt-1; ready = 0.
  - cnt == 0 (last bit): ready = 1. If load = 1: reload sreg <= data, cnt <= WIDTH-1, stay in SHIFT. Else go to IDLE.
- load while ready = 0 is ignored; no error flag, no queuing; data is don't-care.
- ready, valid, done, out are decoded from registered state only; no combinational path from load/data to any output.
- cnt never wraps: decremented only when nonzero, reloaded only on accept.

## Timing
- Reset values (async, immediate, also mid-word): state IDLE, sreg 0, cnt 0, ready 1, valid 0, out 0, done 0. The partially sent word is dropped; no further bits emitted.
- Reset deassertion: first accept possible at the first rising edge with reset = 1.
- Latency: word accepted at edge k → bit 0 of the sequence on out during cycle k..k+1, last bit during cycle k+WIDTH-1..k+WIDTH; done high in that last cycle.
- Throughput: one word per WIDTH clocks with load held high; valid stays continuously high across word boundaries.
- Receiver alignment: a receiver clocked by the same clock, sampling out while valid = 1, holds the full word after the edge at which done = 1 is sampled (edge k+WIDTH).
- Simultaneous last bit and load: the last bit is still emitted that cycle; the new word's first bit follows on the next cycle.

## Structure
- Package serializador_pkg: state typedef (IDLE, SHIFT), state encoding constants, cnt width function.
- One sub-module is natural: contador_bits (load value, decrement, zero flag), instantiated once. FSM and shift register remain in the top module.

## Test plan
- Reset: hold reset = 0 with load = 1, data = 4'hF → ready 1, valid 0, out 0, done 0 throughout; no shift activity.
- Single word, WIDTH 4, MSB_FIRST 1: load 4'b1011 for one edge → out 1,0,1,1 in the next four cycles, valid high for exactly 4 cycles, done only in the 4th, ready low for the first 3 bits.
- Back-to-back: load held high with 4'b1011 then 4'b0110 → 8 consecutive valid bits 1,0,1,1,0,1,1,0, done in cycles 4 and 8, no idle gap.
- Busy load ignored: load 4'b1100, then pulse load with 4'b0011 during the 2nd bit → out 1,1,0,0 only; block then returns to IDLE.
- Reset mid-word: load 4'b1111, assert reset after the 2nd bit between edges → out, valid drop to 0 immediately; after release, idle until next load.
- Loopback + LSB_FIRST 0: drive a 4-bit serial-in receiver from out; load 4'b1001 → receiver Q3..Q0 = 1001 after the done edge; repeat with MSB_FIRST 0, checking bit order reverses.
